// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI serial-flash read responder.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_JEDEC = 8'h9F;

    // clk must run at least this many times faster than SCK
    localparam int MIN_CLK_RATIO = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus registered one-cycle
// rise/fall pulses taken from the synchronized level.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 responder emulating the read side of a 25-series flash:
// serves READ (0x03) and JEDEC ID (0x9F) from a synchronous memory port.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int          AW       = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_cs,
    input  logic          spi_clk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          cmd_err
);

    logic cs_sync, cs_rise, cs_fall;
    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_meta, mosi_sync;

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (spi_cs),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (spi_clk),
        .sync (sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    state_t        state;
    logic [4:0]    bit_cnt;
    logic [6:0]    cmd_sr;
    logic [AW-1:0] addr_sr;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] next_addr;
    logic [7:0]    hold;
    logic [7:0]    sr_out;
    logic [1:0]    id_idx;
    logic          load_next;
    logic          rd_pend;
    logic          rd_fire;
    logic          abort;
    logic          sck_r;
    logic          sck_f;
    logic [7:0]    opcode;

    // CS high wins over any SCK event seen in the same cycle
    assign abort  = cs_sync | cs_rise;
    assign sck_r  = sck_rise & ~abort;
    assign sck_f  = sck_fall & ~abort;
    assign opcode = {cmd_sr, mosi_sync};

    always_comb begin
        next_addr = addr_q + 1'b1;
        if (state == ADDR) begin
            next_addr = {addr_sr[AW-2:0], mosi_sync};
        end
    end

    // The read strobe coincides with the sampling rising event so the
    // holding register is ready two cycles later.
    assign rd_fire   = sck_r && (((state == ADDR) && (bit_cnt == 5'd23)) ||
                                 ((state == DATA) && (bit_cnt == 5'd7)));
    assign mem_rd_en = rd_fire;
    assign mem_addr  = rd_fire ? next_addr : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            addr_sr     <= '0;
            addr_q      <= '0;
            hold        <= '0;
            sr_out      <= '0;
            id_idx      <= '0;
            load_next   <= 1'b0;
            rd_pend     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err     <= 1'b0;
            rd_pend     <= rd_fire;
            spi_miso_oe <= ~cs_sync;
            if (rd_pend) begin
                hold <= mem_rdata;
            end

            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                cmd_sr    <= '0;
                addr_sr   <= '0;
                sr_out    <= '0;
                spi_miso  <= 1'b0;
                load_next <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_r) begin
                            cmd_sr  <= opcode[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (opcode)
                                    OP_READ: state <= ADDR;
                                    OP_JEDEC: begin
                                        state     <= ID;
                                        hold      <= JEDEC_ID[23:16];
                                        id_idx    <= 2'd1;
                                        load_next <= 1'b1;
                                    end
                                    default: begin
                                        state   <= IGNORE;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_r) begin
                            addr_sr <= next_addr;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (rd_fire) begin
                                addr_q    <= next_addr;
                                bit_cnt   <= '0;
                                state     <= DATA;
                                load_next <= 1'b1;
                            end
                        end
                    end
                    DATA, ID: begin
                        if (sck_f) begin
                            if (load_next) begin
                                sr_out    <= hold;
                                spi_miso  <= hold[7];
                                load_next <= 1'b0;
                            end else begin
                                sr_out   <= {sr_out[6:0], 1'b0};
                                spi_miso <= sr_out[6];
                            end
                        end
                        if (sck_r) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                load_next <= 1'b1;
                                if (state == DATA) begin
                                    addr_q <= next_addr;
                                end else begin
                                    case (id_idx)
                                        2'd1:    hold <= JEDEC_ID[15:8];
                                        2'd2:    hold <= JEDEC_ID[7:0];
                                        default: hold <= 8'h00;
                                    endcase
                                    if (id_idx != 2'd3) begin
                                        id_idx <= id_idx + 2'd1;
                                    end
                                end
                            end
                        end
                    end
                    IGNORE: spi_miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_slave.sv
// Self-checking bench for spi_flash_slave: directed vector table, random
// transactions against a byte-level reference model, abort and reset cases.
module tb_spi_flash_slave;
    import spi_flash_pkg::*;

    localparam int          AW  = 16;
    localparam logic [23:0] JID = 24'hEF4018;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_cs = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          cmd_err;

    always #5 clk = ~clk;

    spi_flash_slave #(.AW(AW), .JEDEC_ID(JID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    // Synchronous memory: data one clk after the strobe
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    logic [AW-1:0] rd_log[$];
    int err_pulses = 0;
    always @(negedge clk) begin
        if (mem_rd_en) rd_log.push_back(mem_addr);
        if (cmd_err) err_pulses++;
    end

    int checks = 0, errors = 0;
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic oe_mid, busy_mid, busy_after, oe_after;
    int hdr, rd_start, err_start, n_rd, n_err;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          ndata;
        int          half;
        bit          cs_last;
        logic [31:0] exp_data;
        int          exp_err;
        int          exp_nrd;
        logic [31:0] exp_addrs;
    } vec_t;
    vec_t vecs [7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int half, output logic r);
        spi_mosi = b;
        tick(half);
        r = spi_miso;
        spi_clk = 1'b1;
        tick(half);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input int nbits, input int half, input int setup, input bit cs_last);
        logic r;
        for (int k = 0; k < 16; k++) rx_buf[k] = 8'h00;
        spi_cs = 1'b0;
        tick(setup);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx_buf[i/8][3'(7 - i%8)];
            tick(half);
            r = spi_miso;
            if (i == 0) begin
                oe_mid   = spi_miso_oe;
                busy_mid = busy;
            end
            rx_buf[i/8][3'(7 - i%8)] = r;
            spi_clk = 1'b1;
            if (i == nbits - 1 && cs_last) begin
                spi_cs = 1'b1;
                tick(3);
                busy_after = busy;
                oe_after   = spi_miso_oe;
                tick(half - 3);
                spi_clk = 1'b0;
            end else begin
                tick(half);
                spi_clk = 1'b0;
            end
        end
        if (!cs_last) begin
            tick(half);
            spi_cs = 1'b1;
            tick(3);
            busy_after = busy;
            oe_after   = spi_miso_oe;
        end
        tick(6);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int ndata,
                           input int half, input int setup, input bit cs_last);
        tx_buf[0] = op;
        hdr = (op == OP_READ) ? 4 : 1;
        if (op == OP_READ) begin
            tx_buf[1] = addr[23:16];
            tx_buf[2] = addr[15:8];
            tx_buf[3] = addr[7:0];
        end
        for (int k = 0; k < ndata; k++) tx_buf[hdr+k] = 8'hFF;
        rd_start  = rd_log.size();
        err_start = err_pulses;
        xfer((hdr + ndata) * 8, half, setup, cs_last);
        n_rd  = rd_log.size() - rd_start;
        n_err = err_pulses - err_start;
    endtask

    // Reference: what a 25-series flash returns for byte k of the data phase
    function automatic logic [7:0] ref_byte(input logic [7:0] op, input logic [23:0] addr, input int k);
        if (op == OP_READ) return mem[(int'(addr[AW-1:0]) + k) % (1 << AW)];
        if (op == OP_JEDEC) return (k < 3) ? 8'(JID >> (16 - 8*k)) : 8'h00;
        return 8'h00;
    endfunction

    initial begin
        logic [31:0] act;
        logic [15:0] a0, a1;
        logic [7:0] op;
        logic [23:0] addr;
        int nd, hf, exp_nrd;
        bit cl;
        logic r;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'h77;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3;

        vecs[0] = '{8'h03, 24'h000010, 2, 4,  1'b1, 32'h0000A53C, 0, 2, 32'h00100011};
        vecs[1] = '{8'h9F, 24'h000000, 4, 4,  1'b0, 32'hEF401800, 0, 0, 32'h00000000};
        vecs[2] = '{8'h03, 24'h12FFFF, 2, 4,  1'b1, 32'h00005AC3, 0, 2, 32'hFFFF0000};
        vecs[3] = '{8'h55, 24'h000000, 2, 4,  1'b0, 32'h00000000, 1, 0, 32'h00000000};
        vecs[4] = '{8'h03, 24'h000010, 3, 10, 1'b0, 32'h00A53C77, 0, 4, 32'h00100011};
        vecs[5] = '{8'h9F, 24'h000000, 3, 10, 1'b1, 32'h00EF4018, 0, 0, 32'h00000000};
        vecs[6] = '{8'h03, 24'h00FFFF, 1, 4,  1'b0, 32'h0000005A, 0, 2, 32'hFFFF0000};

        tick(3);
        chk("reset miso", 32'(spi_miso), 0);
        chk("reset oe", 32'(spi_miso_oe), 0);
        chk("reset rd_en", 32'(mem_rd_en), 0);
        chk("reset addr", 32'(mem_addr), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset cmd_err", 32'(cmd_err), 0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].ndata, vecs[i].half, 2 + i, vecs[i].cs_last);
            act = 0;
            for (int k = 0; k < vecs[i].ndata; k++) act = {act[23:0], rx_buf[hdr+k]};
            a0 = (n_rd > 0) ? rd_log[rd_start] : 16'h0;
            a1 = (n_rd > 1) ? rd_log[rd_start+1] : 16'h0;
            chk($sformatf("vec%0d data", i), act, vecs[i].exp_data);
            chk($sformatf("vec%0d cmd_err", i), 32'(n_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d rd_count", i), 32'(n_rd), 32'(vecs[i].exp_nrd));
            chk($sformatf("vec%0d rd_addrs", i), {a0, a1}, vecs[i].exp_addrs);
            chk($sformatf("vec%0d busy_mid", i), 32'(busy_mid), 1);
            chk($sformatf("vec%0d oe_mid", i), 32'(oe_mid), 1);
            chk($sformatf("vec%0d busy_after_cs", i), 32'(busy_after), 0);
            chk($sformatf("vec%0d oe_after_cs", i), 32'(oe_after), 0);
        end

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0: op = OP_READ;
                1: op = OP_JEDEC;
                default: begin
                    op = 8'($urandom);
                    while (op == OP_READ || op == OP_JEDEC) op = 8'($urandom);
                end
            endcase
            addr = 24'($urandom);
            nd   = $urandom_range(1, 4);
            hf   = ($urandom_range(0, 1) == 0) ? MIN_CLK_RATIO / 2 : 10;
            cl   = 1'($urandom_range(0, 1));
            run_txn(op, addr, nd, hf, $urandom_range(1, 8), cl);
            for (int k = 0; k < nd; k++)
                chk($sformatf("rnd%0d op%h byte%0d", t, op, k), 32'(rx_buf[hdr+k]), 32'(ref_byte(op, addr, k)));
            exp_nrd = (op == OP_READ) ? nd + (cl ? 0 : 1) : 0;
            chk($sformatf("rnd%0d rd_count", t), 32'(n_rd), 32'(exp_nrd));
            for (int j = 0; j < exp_nrd && j < n_rd; j++)
                chk($sformatf("rnd%0d rd_addr%0d", t, j), 32'(rd_log[rd_start+j]),
                    32'((int'(addr[AW-1:0]) + j) % (1 << AW)));
            chk($sformatf("rnd%0d cmd_err", t), 32'(n_err), (op != OP_READ && op != OP_JEDEC) ? 1 : 0);
            chk($sformatf("rnd%0d busy_after_cs", t), 32'(busy_after), 0);
        end

        // Abort after 10 address bits, then a clean read
        tx_buf[0] = OP_READ; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF;
        rd_start = rd_log.size();
        err_start = err_pulses;
        xfer(18, 4, 3, 1'b0);
        chk("abort rd_count", 32'(rd_log.size() - rd_start), 0);
        chk("abort cmd_err", 32'(err_pulses - err_start), 0);
        chk("abort busy_after_cs", 32'(busy_after), 0);
        run_txn(OP_READ, 24'h000010, 1, 4, 3, 1'b0);
        chk("post_abort data", 32'(rx_buf[4]), 32'h A5);
        chk("post_abort rd_addr", (n_rd > 0) ? 32'(rd_log[rd_start]) : 32'hFFFF_FFFF, 32'h10);

        // Asynchronous reset in the middle of a data byte
        tx_buf[0] = OP_READ; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h10;
        spi_cs = 1'b0;
        tick(3);
        for (int i = 0; i < 32; i++) send_bit(tx_buf[i/8][3'(7 - i%8)], 4, r);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 4, r);
        chk("pre_reset busy", 32'(busy), 1);
        chk("pre_reset addr", 32'(mem_addr), 32'h10);
        chk("pre_reset miso", 32'(spi_miso), 32'(mem[16'h0010][5]));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_reset miso", 32'(spi_miso), 0);
        chk("mid_reset oe", 32'(spi_miso_oe), 0);
        chk("mid_reset rd_en", 32'(mem_rd_en), 0);
        chk("mid_reset addr", 32'(mem_addr), 0);
        chk("mid_reset busy", 32'(busy), 0);
        chk("mid_reset cmd_err", 32'(cmd_err), 0);
        spi_cs = 1'b1;
        spi_clk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        run_txn(OP_READ, 24'h000011, 1, 4, 2, 1'b0);
        chk("post_reset data", 32'(rx_buf[4]), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_flash_slave.md
# spi_flash_slave

Synthesizable SPI mode-0 responder that emulates the read side of a 25-series serial flash, the device that sits at the far end of the SoC's spi0 master pins. It is clocked by the system clock, oversamples the SPI pins, and serves `READ` (0x03) and `JEDEC ID` (0x9F) from a synchronous memory read port. It lets the team boot-from-flash and test the SPI driver in RTL simulation and on FPGA without a vendor flash model.

## Interface
Parameters:
- `AW`, 16: memory address width. The low `AW` bits of the 24-bit SPI address are used; the upper bits are ignored.
- `JEDEC_ID`, 24'hEF4018: the three ID bytes, returned MSB first.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock. Must be at least 8× the SCK frequency.
- `rst_n` in 1: asynchronous active-low reset.
- `spi_cs` in 1: chip select, active low. Asynchronous to `clk`.
- `spi_clk` in 1: SCK. Asynchronous to `clk`.
- `spi_mosi` in 1: serial data in.
- `spi_miso` out 1: serial data out.
- `spi_miso_oe` out 1: output enable for the MISO pad. High while CS is active after synchronization.
- `mem_addr` out AW: read address.
- `mem_rd_en` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, valid exactly 1 `clk` after `mem_rd_en`.
- `busy` out 1: high whenever the FSM is not in `IDLE`.
- `cmd_err` out 1: one-cycle pulse when an unsupported opcode is received.

## Operation
- Synchronization and edge detect:
  - `spi_cs`, `spi_clk` and `spi_mosi` each pass through a 2-flop synchronizer.
  - SCK rising and falling events are single-cycle pulses derived from the synchronized SCK.
  - SCK edges are ignored while the synchronized CS is high.
- Bit order and mode:
  - MSB first, mode 0.
  - MOSI is sampled on each SCK rising event.
  - MISO updates on each SCK falling event.
- FSM states: `IDLE`, `CMD`, `ADDR`, `DATA`, `ID`, `IGNORE`.
  - `IDLE` → `CMD` on the synchronized CS falling edge. The bit counter clears.
  - `CMD`: after 8 bits, opcode 0x03 → `ADDR`; opcode 0x9F → `ID`; any other opcode → `IGNORE` with `cmd_err` pulsed for one cycle.
  - `ADDR`: 24 bits are shifted in. On the rising event of bit 0, assert `mem_rd_en` with `mem_addr` = addr[AW-1:0], latch `mem_rdata` one cycle later into the output holding register, then → `DATA`.
  - `DATA`:
    - Each falling event shifts out the next bit.
    - At the first falling event of a byte, the holding register is loaded into the shift register and bit 7 is driven.
    - On the rising event of the byte's 8th bit, the address increments and the next byte is fetched.
    - The address wraps modulo 2^AW.
    - Streaming continues until CS goes high.
  - `ID`: `JEDEC_ID` bytes are shifted out in the same manner; after the 3rd byte, 0x00 is shifted out.
  - `IGNORE`: MISO is held at 0 until CS goes high.
- Abort: synchronized CS going high in any state → `IDLE` on the next `clk`.
  - The abort clears the bit counter and partial shift registers and drops `spi_miso_oe`.
  - No memory read is issued after the abort.
- Simultaneous events: if CS rising and an SCK event are detected in the same cycle, CS wins and the SCK event is discarded.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `mem_rd_en`=0, `mem_addr`=0, `busy`=0, `cmd_err`=0; FSM in `IDLE`.
- Pin-to-event latency is 2 `clk` (synchronizer) plus 1 `clk` (edge register).
- Read turnaround: `mem_rd_en` is asserted in the same cycle as the sampling rising event. The holding register is valid 2 cycles later. The next falling event arrives at least 4 `clk` after the rising event because of the 8× ratio, so data is always ready.
- `spi_miso` changes exactly 1 `clk` after the falling event is detected.
- `cmd_err` is high for exactly 1 cycle per bad command.

## Structure
- Package `spi_flash_pkg` holds:
  - the FSM state enum;
  - opcode constants `OP_READ`=8'h03 and `OP_JEDEC`=8'h9F;
  - the minimum clock ratio constant (8).
- Sub-module `spi_pin_sync`: a 2-flop synchronizer plus registered rise/fall pulse outputs. It is instantiated for `spi_clk` and `spi_cs`; `spi_mosi` uses only the synchronizer. The FSM, shifters and address counter form the top-level module.

## Test plan
- Memory preloaded with mem[0x0010]=0xA5 and mem[0x0011]=0x3C. Send 0x03, 0x000010, then clock 16 bits → MISO returns 0xA5, 0x3C; exactly two `mem_rd_en` pulses, at `mem_addr` 0x0010 and 0x0011.
- Send 0x9F, then clock 32 bits → MISO returns 0xEF, 0x40, 0x18, 0x00; no `mem_rd_en` pulses.
- With `AW`=16, read starting at address 0x12FFFF for 2 bytes → returns mem[0xFFFF], then mem[0x0000]; `mem_addr` wraps to 0.
- Send opcode 0x55 → one `cmd_err` pulse; MISO stays 0 for the next 16 SCKs; `busy` drops within 3 `clk` after CS goes high.
- Raise CS after 10 address bits, then issue a full `READ` of 0x000010 → first byte is 0xA5 with no residue from the aborted transfer. Separately, assert `rst_n` low mid-`DATA` → all outputs return to their reset values immediately.
- SCK at exactly `clk`/8 and `clk`/20 with random CS-to-SCK setup times → all bytes match the memory contents.
